// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder and lane-alignment logic.
package mem_responder_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_addr_t;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_WAIT,
    MS_RESP
  } mem_state_t;

  function automatic logic misaligned(input mem_addr_t size, input logic [1:0] a);
    case (size)
      MEM_H, MEM_HU: return a[0];
      MEM_W:         return |a;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables/replication and load extract/extend.
module mem_lane_align
  import mem_responder_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  mem_addr_t   size;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign size  = mem_addr_t'(size_i);
  assign rhalf = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

  always_comb begin
    rbyte = rword_i[7:0];
    case (addr_lo_i)
      2'd1:    rbyte = rword_i[15:8];
      2'd2:    rbyte = rword_i[23:16];
      2'd3:    rbyte = rword_i[31:24];
      default: rbyte = rword_i[7:0];
    endcase
  end

  always_comb begin
    be_o    = 4'hF;
    wdata_o = wdata_i;
    rdata_o = rword_i;
    case (size)
      MEM_B, MEM_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      MEM_H, MEM_HU: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
    case (size)
      MEM_B:   rdata_o = {{24{rbyte[7]}}, rbyte};
      MEM_BU:  rdata_o = {24'b0, rbyte};
      MEM_H:   rdata_o = {{16{rhalf[15]}}, rhalf};
      MEM_HU:  rdata_o = {16'b0, rhalf};
      default: rdata_o = rword_i;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Word-SRAM memory responder with programmable wait states; drives RESET_PC during reset.
// SUROV_MEM_ERR_EN enables misalignment/out-of-range faults (default: force-align and wrap).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [2:0]  mem_size_i,
  input  logic [31:0] memwrite_data_i,
  output logic [31:0] memread_data_o,
  output logic        mem_ready_o,
  output logic        mem_err_o
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [3:0]  WCNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  mem_state_t     state_q, state_d;
  logic [3:0]     wait_cnt_q, wait_cnt_d;
  logic [AW+1:0]  addr_q;
  mem_addr_t      size_q;
  logic           we_q;
  word_t          wdata_q;
  word_t          rdata_q;
  word_t          sram [DEPTH];

  logic           accept;
  logic           in_resp;
  logic           err;
  logic [AW-1:0]  widx;
  logic [3:0]     be;
  word_t          wrep;
  word_t          rext;
  word_t          resp_data;

  assign accept    = (state_q == MS_IDLE) && mem_req_i;
  assign in_resp   = (state_q == MS_RESP);
  assign widx      = addr_q[AW+1:2];
  assign resp_data = err ? '0 : rext;

`ifdef SUROV_MEM_ERR_EN
  logic oor_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    oor_q <= 1'b0;
    else if (accept) oor_q <= |mem_addr_i[31:AW+2];
  end
  assign err = oor_q | misaligned(size_q, addr_q[1:0]);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_addr_i[31:AW+2];
  assign err = 1'b0;
`endif

  mem_lane_align u_align (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rword_i   (sram[widx]),
    .be_o      (be),
    .wdata_o   (wrep),
    .rdata_o   (rext)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= MS_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      MS_IDLE: if (mem_req_i) begin
        wait_cnt_d = WCNT_INIT;
        state_d    = (WAIT_STATES == 0) ? MS_RESP : MS_WAIT;
      end
      MS_WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = MS_RESP;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      MS_RESP: state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  always_comb begin
    mem_ready_o    = in_resp;
    mem_err_o      = in_resp & err;
    memread_data_o = in_resp ? resp_data : rdata_q;
    if (!rst_n_i) memread_data_o = RESET_PC;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q  <= '0;
      size_q  <= MEM_W;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= RESET_PC;
    end else begin
      if (accept) begin
        addr_q  <= mem_addr_i[AW+1:0];
        size_q  <= mem_addr_t'(mem_size_i);
        we_q    <= mem_we_i;
        wdata_q <= memwrite_data_i;
      end
      if (in_resp) rdata_q <= resp_data;
    end
  end

  // SRAM is never reset; gating on rst_n_i drops a store caught by reset on its commit edge.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && in_resp && we_q && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) sram[widx][8*b +: 8] <= wrep[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder against a byte-array reference model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WS    = 1;
  localparam logic [31:0] RPC   = 32'h8000_0000;
  localparam int unsigned SPAN  = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [2:0]  mem_size;
  logic [31:0] memwrite_data;
  logic [31:0] memread_data;
  logic        mem_ready;
  logic        mem_err;

  mem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS),
    .RESET_PC    (RPC),
    .INIT_FILE   ("")
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .mem_req_i       (mem_req),
    .mem_we_i        (mem_we),
    .mem_addr_i      (mem_addr),
    .mem_size_i      (mem_size),
    .memwrite_data_i (memwrite_data),
    .memread_data_o  (memread_data),
    .mem_ready_o     (mem_ready),
    .mem_err_o       (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_load;
    bit          exp_err;
    logic [31:0] exp_data;
    int          exp_cyc;
    int          id;
  } sb_t;

  sb_t            sbq[$];
  byte unsigned   mm [SPAN];
  int             cyc = 0;
  int             total = 0;
  int             bad = 0;
  int             op_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s op=%0d: got %h want %h", nm, id, act, exp);
    end
  endtask

  // Reference: memory is a flat byte array; sizes are byte counts with natural alignment.
  function automatic void model_op(input bit we, input logic [2:0] sz, input logic [31:0] a,
                                   input logic [31:0] wd, output logic [31:0] rd, output bit er);
    int unsigned ea;
    int          n;
    logic [31:0] v;
    rd = '0;
    er = 1'b0;
`ifdef SUROV_MEM_ERR_EN
    if (a >= SPAN || ((sz == MEM_H || sz == MEM_HU) && a[0]) || (sz == MEM_W && a[1:0] != 2'b00)) begin
      er = 1'b1;
      return;
    end
`endif
    ea = a % SPAN;
    n  = 4;
    if (sz == MEM_B || sz == MEM_BU) n = 1;
    if (sz == MEM_H || sz == MEM_HU) n = 2;
    ea = ea - (ea % n);
    if (we) begin
      for (int i = 0; i < n; i++) mm[ea + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mm[ea + i]) << (8 * i));
      if (sz == MEM_B && v[7])  v = v | 32'hFFFF_FF00;
      if (sz == MEM_H && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endfunction

  task automatic do_op(input bit we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    sb_t         e;
    logic [31:0] rd;
    bit          er;
    int          t;
    model_op(we, sz, a, wd, rd, er);
    @(posedge clk); #1;
    mem_req       = 1'b1;
    mem_we        = we;
    mem_size      = sz;
    mem_addr      = a;
    memwrite_data = wd;
    op_id++;
    e.is_load  = !we;
    e.exp_err  = er;
    e.exp_data = rd;
    e.exp_cyc  = cyc + WS + 1;
    e.id       = op_id;
    sbq.push_back(e);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mem_ready && t < 50);
    if (!mem_ready) begin
      check("ready_timeout", op_id, 32'd0, 32'd1);
      void'(sbq.pop_back());
    end
    @(posedge clk); #1;
    mem_req = 1'b0;
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (rst_n && mem_ready) begin
      if (sbq.size() == 0) begin
        check("spurious_ready", -1, 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("latency", e.id, cyc, e.exp_cyc);
        check("mem_err", e.id, {31'b0, mem_err}, {31'b0, e.exp_err});
        if (e.is_load || e.exp_err) check("rdata", e.id, memread_data, e.exp_data);
      end
    end
  end

  initial begin
    logic [2:0] szs [5];
    szs[0] = MEM_B; szs[1] = MEM_H; szs[2] = MEM_W; szs[3] = MEM_BU; szs[4] = MEM_HU;
    rst_n = 1'b1;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_size = MEM_W; memwrite_data = '0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_pc", 0, memread_data, RPC);
    check("reset_ready", 0, {31'b0, mem_ready}, 32'd0);
    check("reset_err", 0, {31'b0, mem_err}, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    for (int w = 0; w < int'(DEPTH); w++) do_op(1'b1, MEM_W, 32'(w * 4), $urandom);

    do_op(1'b1, MEM_W,  32'h10, 32'hDEAD_BEEF);
    do_op(1'b0, MEM_W,  32'h10, 32'h0);
    do_op(1'b1, MEM_B,  32'h13, 32'h0000_0080);
    do_op(1'b0, MEM_B,  32'h13, 32'h0);
    do_op(1'b0, MEM_BU, 32'h13, 32'h0);
    do_op(1'b0, MEM_W,  32'h10, 32'h0);
    do_op(1'b1, MEM_H,  32'h22, 32'h0000_8001);
    do_op(1'b0, MEM_H,  32'h22, 32'h0);
    do_op(1'b0, MEM_HU, 32'h22, 32'h0);
    do_op(1'b0, MEM_W,  32'h20, 32'h0);

    // Store abandoned by a reset pulse while waiting; the old word must survive.
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = MEM_W; mem_addr = 32'h30; memwrite_data = 32'h1234_5678;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midreset_pc", 0, memread_data, RPC);
    check("midreset_ready", 0, {31'b0, mem_ready}, 32'd0);
    mem_req = 1'b0;
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    do_op(1'b0, MEM_W, 32'h30, 32'h0);

    do_op(1'b0, MEM_W,  32'h12, 32'h0);
    do_op(1'b0, MEM_HU, 32'h21, 32'h0);
    do_op(1'b1, MEM_W,  SPAN, 32'hCAFE_F00D);
    do_op(1'b0, MEM_W,  32'h0, 32'h0);
    do_op(1'b0, MEM_W,  SPAN + 32'h10, 32'h0);

    for (int i = 0; i < 250; i++) begin
      do_op(1'($urandom_range(1)), szs[$urandom_range(4)], 32'($urandom_range(SPAN * 2 - 1)), $urandom);
    end

    for (int t = 0; t < 20 && sbq.size() != 0; t++) @(posedge clk);
    if (sbq.size() != 0) check("drain", 0, sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
